// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous
// instruction memory with 1-cycle read latency (slave).
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic            imem_en;
    logic [31:0]     imem_rdata;

    modport master (output imem_addr, output imem_en, input imem_rdata);
    modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch front end: PC, in-flight read slot, 1-entry skid, IF/ID register.
// Optional macro FETCH_PERF_EN adds stall_cnt / flush_cnt performance counters.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] PCTargetE,
    fetch_stage_if.master   imem,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    logic [XLEN-1:0] PCF;
    logic            f2_valid;
    logic [XLEN-1:0] f2_pc;
    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic            src_valid;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;

    assign imem.imem_addr = PCF;
    assign imem.imem_en   = !rst && !stall && !flush;

    // The skid always holds an older instruction than the F2 slot, so it wins.
    always_comb begin
        src_valid = 1'b0;
        src_instr = NOP_INSTR;
        src_pc    = '0;
        if (skid_valid) begin
            src_valid = 1'b1;
            src_instr = skid_instr;
            src_pc    = skid_pc;
        end else if (f2_valid) begin
            src_valid = 1'b1;
            src_instr = imem.imem_rdata;
            src_pc    = f2_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PCF        <= RESET_PC;
            f2_valid   <= 1'b0;
            skid_valid <= 1'b0;
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
        end else if (flush) begin
            PCF        <= PCTargetE & ~XLEN'(3);
            f2_valid   <= 1'b0;
            skid_valid <= 1'b0;
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            ValidD     <= 1'b0;
        end else if (stall) begin
            // Data returning during a stall would be lost next cycle; park it.
            if (f2_valid) begin
                skid_valid <= 1'b1;
                skid_instr <= imem.imem_rdata;
                skid_pc    <= f2_pc;
            end
            f2_valid <= 1'b0;
        end else begin
            InstrD     <= src_instr;
            PCD        <= src_pc;
            PCPlus4D   <= src_valid ? src_pc + XLEN'(4) : '0;
            ValidD     <= src_valid;
            f2_pc      <= PCF;
            f2_valid   <= 1'b1;
            PCF        <= PCF + XLEN'(4);
            skid_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush) flush_cnt <= flush_cnt + 32'd1;
            else if (stall) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan scenarios plus random
// stall/flush/reset traffic against a queue-based fetch-stream model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC [2] = '{32'h0000_0000, 32'hFFFF_FFF8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_in [2];
    logic        s_in [2];
    logic        f_in [2];
    logic [31:0] t_in [2];

    logic [31:0] o_instr [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_p4    [2];
    logic        o_valid [2];
`ifdef FETCH_PERF_EN
    logic [31:0] o_sc [2];
    logic [31:0] o_fc [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage_if #(.XLEN(32)) bus_a ();
    fetch_stage_if #(.XLEN(32)) bus_b ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut_a (
        .clk(clk), .rst(r_in[0]), .stall(s_in[0]), .flush(f_in[0]), .PCTargetE(t_in[0]),
        .imem(bus_a),
        .InstrD(o_instr[0]), .PCD(o_pc[0]), .PCPlus4D(o_p4[0]), .ValidD(o_valid[0])
`ifdef FETCH_PERF_EN
        , .stall_cnt(o_sc[0]), .flush_cnt(o_fc[0])
`endif
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut_b (
        .clk(clk), .rst(r_in[1]), .stall(s_in[1]), .flush(f_in[1]), .PCTargetE(t_in[1]),
        .imem(bus_b),
        .InstrD(o_instr[1]), .PCD(o_pc[1]), .PCPlus4D(o_p4[1]), .ValidD(o_valid[1])
`ifdef FETCH_PERF_EN
        , .stall_cnt(o_sc[1]), .flush_cnt(o_fc[1])
`endif
    );

    // Program image: two fixed words at 0/4, a unique word everywhere else.
    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Output is garbage whenever no read was issued, so stale data cannot be relied on.
    always @(posedge clk) begin
        bus_a.imem_rdata <= bus_a.imem_en ? memw(bus_a.imem_addr) : $urandom;
        bus_b.imem_rdata <= bus_b.imem_en ? memw(bus_b.imem_addr) : $urandom;
    end

    // Reference model: next fetch address plus a FIFO of fetched, undelivered PCs.
    logic [31:0] m_pcf [2];
    logic [31:0] m_q   [2][4];
    int          m_n   [2];
    bit          m_init [2];
    logic [31:0] e_instr [2];
    logic [31:0] e_pc    [2];
    logic [31:0] e_p4    [2];
    logic        e_valid [2];
    bit          e_pcchk [2];
    logic [31:0] e_sc [2];
    logic [31:0] e_fc [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble(input int i, input bit pcchk);
        e_valid[i] = 1'b0;
        e_instr[i] = NOP;
        e_pc[i]    = 32'h0;
        e_p4[i]    = 32'h0;
        e_pcchk[i] = pcchk;
    endtask

    task automatic model_step(input int i);
        if (r_in[i]) begin
            m_pcf[i] = RPC[i];
            m_n[i] = 0;
            m_init[i] = 1'b1;
            e_sc[i] = 0;
            e_fc[i] = 0;
            bubble(i, 1'b1);
        end else if (!m_init[i]) begin
        end else if (f_in[i]) begin
            m_pcf[i] = {t_in[i][31:2], 2'b00};
            m_n[i] = 0;
            e_fc[i] = e_fc[i] + 1;
            bubble(i, 1'b1);
        end else if (s_in[i]) begin
            e_sc[i] = e_sc[i] + 1;
        end else begin
            if (m_n[i] > 0) begin
                e_valid[i] = 1'b1;
                e_pc[i]    = m_q[i][0];
                e_p4[i]    = m_q[i][0] + 32'd4;
                e_instr[i] = memw(m_q[i][0]);
                e_pcchk[i] = 1'b1;
                for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
                m_n[i]--;
            end else begin
                bubble(i, 1'b0);
            end
            if (m_n[i] < 4) begin
                m_q[i][m_n[i]] = m_pcf[i];
                m_n[i]++;
            end
            m_pcf[i] = m_pcf[i] + 32'd4;
        end
    endtask

    task automatic cycle();
        logic en, excl;
        logic [31:0] addr;
        #1;
        for (int i = 0; i < 2; i++) begin
            en   = (i == 0) ? bus_a.imem_en : bus_b.imem_en;
            addr = (i == 0) ? bus_a.imem_addr : bus_b.imem_addr;
            check($sformatf("imem_en[%0d]", i), {31'b0, en}, {31'b0, !r_in[i] && !s_in[i] && !f_in[i]});
            if (m_init[i]) check($sformatf("imem_addr[%0d]", i), addr, m_pcf[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!m_init[i]) continue;
            check($sformatf("ValidD[%0d]", i), {31'b0, o_valid[i]}, {31'b0, e_valid[i]});
            check($sformatf("InstrD[%0d]", i), o_instr[i], e_instr[i]);
            if (e_pcchk[i]) begin
                check($sformatf("PCD[%0d]", i), o_pc[i], e_pc[i]);
                check($sformatf("PCPlus4D[%0d]", i), o_p4[i], e_p4[i]);
            end
            excl = (i == 0) ? (dut_a.f2_valid && dut_a.skid_valid) : (dut_b.f2_valid && dut_b.skid_valid);
            check($sformatf("skid_f2_excl[%0d]", i), {31'b0, excl}, 32'h0);
`ifdef FETCH_PERF_EN
            check($sformatf("stall_cnt[%0d]", i), o_sc[i], e_sc[i]);
            check($sformatf("flush_cnt[%0d]", i), o_fc[i], e_fc[i]);
`endif
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 2; i++) begin
            r_in[i] = 1'b1; s_in[i] = 1'b0; f_in[i] = 1'b0; t_in[i] = 32'h0;
            m_init[i] = 1'b0; m_n[i] = 0; m_pcf[i] = 32'h0;
            e_sc[i] = 0; e_fc[i] = 0;
            bubble(i, 1'b0);
        end

        // Reset state and boot sequence of instance A (B held in reset)
        repeat (2) cycle();
        check("rst_valid", {31'b0, o_valid[0]}, 32'h0);
        check("rst_instr", o_instr[0], NOP);
        check("rst_pcd", o_pc[0], 32'h0);
        check("rst_p4", o_p4[0], 32'h0);
        r_in[0] = 1'b0;
        cycle();
        check("boot_bubble", {31'b0, o_valid[0]}, 32'h0);
        cycle();
        check("boot_instr0", o_instr[0], 32'h0050_0093);
        check("boot_pcd0", o_pc[0], 32'h0);
        check("boot_p40", o_p4[0], 32'h4);
        check("boot_valid0", {31'b0, o_valid[0]}, 32'h1);
        cycle();
        check("boot_instr1", o_instr[0], 32'h00A0_0113);
        check("boot_pcd1", o_pc[0], 32'h4);
        for (int k = 2; k < 8; k++) begin
            cycle();
            check("line_pcd", o_pc[0], 32'(4 * k));
            check("line_valid", {31'b0, o_valid[0]}, 32'h1);
        end

        // Three-cycle stall while PCD=0x8, then release
        r_in[0] = 1'b1; cycle(); r_in[0] = 1'b0;
        repeat (4) cycle();
        check("pre_stall_pcd", o_pc[0], 32'h8);
        s_in[0] = 1'b1;
        repeat (3) begin
            cycle();
            check("stall_hold_pcd", o_pc[0], 32'h8);
            check("stall_imem_en", {31'b0, bus_a.imem_en}, 32'h0);
        end
        s_in[0] = 1'b0;
        cycle();
        check("release_pcd0", o_pc[0], 32'hC);
        check("release_valid", {31'b0, o_valid[0]}, 32'h1);
        cycle();
        check("release_pcd1", o_pc[0], 32'h10);

        // Flush with stall also asserted, target 0x40
        s_in[0] = 1'b1; f_in[0] = 1'b1; t_in[0] = 32'h40;
        cycle();
        check("flush_instr", o_instr[0], NOP);
        check("flush_valid0", {31'b0, o_valid[0]}, 32'h0);
        s_in[0] = 1'b0; f_in[0] = 1'b0;
        cycle();
        check("flush_valid1", {31'b0, o_valid[0]}, 32'h0);
        cycle();
        check("redir_pcd", o_pc[0], 32'h40);
        check("redir_instr", o_instr[0], memw(32'h40));

        // Flush while the skid holds a wrong-path instruction
        cycle();
        s_in[0] = 1'b1;
        cycle();
        check("skid_filled", {31'b0, dut_a.skid_valid}, 32'h1);
        f_in[0] = 1'b1; t_in[0] = 32'h82;
        cycle();
        s_in[0] = 1'b0; f_in[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            cycle();
            if (o_valid[0]) found = 1'b1;
        end
        check("redir_found", {31'b0, found}, 32'h1);
        check("redir_first_pc", o_pc[0], 32'h80);

        // Instance B: RESET_PC near the top of the address space
        r_in[1] = 1'b0;
        repeat (2) cycle();
        check("wrap_pcd0", o_pc[1], 32'hFFFF_FFF8);
        cycle();
        check("wrap_pcd1", o_pc[1], 32'hFFFF_FFFC);
        check("wrap_p41", o_p4[1], 32'h0);
        cycle();
        check("wrap_pcd2", o_pc[1], 32'h0);
        check("wrap_instr2", o_instr[1], 32'h0050_0093);
        s_in[1] = 1'b1;
        repeat (3) cycle();
        s_in[1] = 1'b0; f_in[1] = 1'b1; t_in[1] = 32'h100;
        repeat (2) cycle();
        f_in[1] = 1'b0;
        cycle();
`ifdef FETCH_PERF_EN
        check("perf_stall_cnt", o_sc[1], 32'd3);
        check("perf_flush_cnt", o_fc[1], 32'd2);
`endif

        // Random hazard traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                r_in[i] = ($urandom_range(99) < 1);
                s_in[i] = ($urandom_range(99) < 20);
                f_in[i] = ($urandom_range(99) < 7);
                t_in[i] = $urandom;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage RV32I pipeline.
- Owns the PC register and drives the synchronous instruction memory, which has 1-cycle read latency.
- Contains a 1-entry skid buffer and the IF/ID pipeline register.
- Consumes the hazard unit's `stall`/`flush` and the execute-stage redirect target; produces the decode-stage instruction/PC bundle.

Parameters:
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded into IF/ID on flush/reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: freeze PC and IF/ID this cycle
- flush  in  1  hazard unit: taken branch/JAL/JALR in EX, redirect and squash
- PCTargetE  in  XLEN  redirect target from EX; bits [1:0] ignored (forced 0)
- imem_addr  out  XLEN  instruction memory address (= PCF)
- imem_en  out  1  read enable; data returned next cycle on imem_rdata
- imem_rdata  in  32  instruction for the address issued in the previous cycle
- InstrD  out  32  IF/ID instruction
- PCD  out  XLEN  IF/ID PC
- PCPlus4D  out  XLEN  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Internal state:
  - PCF
  - F2 slot: f2_valid, f2_pc (address issued last cycle, data arriving now)
  - skid: skid_valid, skid_instr, skid_pc
  - IF/ID register
- Reset (rst=1 at edge): PCF=RESET_PC, f2_valid=0, skid_valid=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
- Combinational outputs: imem_addr=PCF always; imem_en = !rst & !stall & !flush.
- Priority per cycle: rst > flush > stall > advance.
- FLUSH:
  - PCF<=PCTargetE & ~3.
  - f2_valid<=0, skid_valid<=0 (in-flight and buffered wrong-path instructions discarded).
  - IF/ID<=NOP_INSTR, PCD/PCPlus4D<=0, ValidD<=0.
  - No memory read this cycle.
  - Flush with stall also asserted is treated as flush.
- STALL:
  - PCF and IF/ID hold; no new read.
  - If f2_valid: skid<={imem_rdata, f2_pc}, skid_valid<=1; then f2_valid<=0.
  - A second consecutive stall cycle leaves skid unchanged.
- ADVANCE (neither asserted):
  - Source selection: skid if skid_valid, else imem_rdata/f2_pc if f2_valid, else bubble (NOP_INSTR, ValidD=0).
  - IF/ID<=source; PCPlus4D = source PC + 4.
  - Read issued at PCF; f2_pc<=PCF; f2_valid<=1.
  - PCF<=PCF+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
  - skid_valid<=0.
- Invariant: skid_valid and f2_valid are never both 1, because no read is issued while stalled. Verification shall assert this.
- Latency:
  - An address issued in cycle n appears on InstrD/ValidD=1 from cycle n+2, if no stall or flush intervenes.
  - Steady-state throughput is 1 instruction per cycle.
  - Post-reset: first ValidD=1 is 2 cycles after rst falls.
- Redirect penalty: a flush in cycle n gives ValidD=0 in cycles n+1 and n+2; target instruction on InstrD in cycle n+3.
- Stall release: the instruction held by the skid is presented the cycle after stall drops, with no lost or duplicated instruction.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined:
  - Adds outputs `stall_cnt` [31:0] and `flush_cnt` [31:0].
  - stall_cnt increments on each cycle with stall=1 & flush=0 & rst=0.
  - flush_cnt increments on each cycle with flush=1 & rst=0.
  - Both counters wrap at 2^32 and are cleared by rst.
- Without the macro: neither port nor counter logic exists; the remaining behaviour is identical.

Test Plan:
- Reset release, memory preloaded mem[0]=0x00500093, mem[4]=0x00A00113 -> cycle 2 after reset: InstrD=0x00500093, PCD=0, PCPlus4D=4, ValidD=1; cycle 3: InstrD=0x00A00113, PCD=4.
- Straight-line run of 8 instructions, no hazards -> PCD sequence 0,4,...,28 on consecutive cycles, ValidD=1 every cycle.
- Stall for 3 cycles while PCD=0x8 -> IF/ID holds 0x8 during the stall; the next cycles show PCD 0xC, 0x10 with no gap, duplicate or skip; imem_en=0 during the stall.
- Flush with PCTargetE=0x40 (stall also 1) while PCD=0x10 -> next cycle InstrD=0x00000013, ValidD=0; ValidD=0 for 2 cycles; then PCD=0x40 with mem[0x40].
- Flush during stall with skid_valid=1 -> skid discarded; the first valid PCD after the redirect equals the target; the old PC never appears.
- RESET_PC=0xFFFF_FFF8 -> PCD sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; PCPlus4D for 0xFFFF_FFFC = 0x0. With FETCH_PERF_EN, after the above: stall_cnt=3, flush_cnt=2.
